// File: rtl/data_delay_line_pkg.sv
// Shared constants and helpers for the data delay line.
// Holds the default word length, default depth and the count-width function.
package data_delay_line_pkg;

   localparam int DEF_WL    = 10;
   localparam int DEF_DEPTH = 4;

   // Smallest number of bits able to hold the values 0 .. value-1.
   function automatic int clog2(input int value);
      int bits;
      int rest;
      bits = 0;
      rest = value - 1;
      while (rest > 0) begin
         bits = bits + 1;
         rest = rest >> 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/data_delay_line_stage.sv
// One stage of the delay line: a W-bit register with async active-low reset,
// synchronous clear (priority) and advance enable.
module delay_stage
   import data_delay_line_pkg::*;
#(
   parameter int W = DEF_WL + 1
)(
   input  logic         iCLK,
   input  logic         iRSTn,
   input  logic         iEN,
   input  logic         iCLR,
   input  logic [W-1:0] iD,
   output logic [W-1:0] oQ
);

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         oQ <= '0;
      end else if (iCLR) begin
         oQ <= '0;
      end else if (iEN) begin
         oQ <= iD;
      end
   end

endmodule

// File: rtl/data_delay_line.sv
// Enabled delay line of DEPTH stages carrying {valid, data}, with a running
// count of valid stages and a primed flag when every stage holds valid data.
module data_delay_line
   import data_delay_line_pkg::*;
#(
   parameter int WL    = DEF_WL,
   parameter int DEPTH = DEF_DEPTH
)(
   input  logic                         iCLK,
   input  logic                         iRSTn,
   input  logic                         iEN,
   input  logic                         iCLR,
   input  logic                         iVALID,
   input  logic [WL-1:0]                iDATA,
   output logic [WL-1:0]                oDATA,
   output logic                         oVALID,
   output logic [clog2(DEPTH+1)-1:0]    oCOUNT,
   output logic                         oPRIMED
);

   localparam int CW = clog2(DEPTH + 1);

   // Each stage word is {valid, data}; the valid bit only qualifies the data
   // for counting, the data itself is captured whatever the valid bit says.
   logic [WL:0] stageD [DEPTH];
   logic [WL:0] stageQ [DEPTH];
   logic        exitValid;

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : gStage
         if (g == 0) begin : gHead
            assign stageD[g] = {iVALID, iDATA};
         end else begin : gLink
            assign stageD[g] = stageQ[g-1];
         end

         delay_stage #(
            .W (WL + 1)
         ) uStage (
            .iCLK  (iCLK),
            .iRSTn (iRSTn),
            .iEN   (iEN),
            .iCLR  (iCLR),
            .iD    (stageD[g]),
            .oQ    (stageQ[g])
         );
      end
   endgenerate

   assign exitValid = stageQ[DEPTH-1][WL];
   assign oDATA     = stageQ[DEPTH-1][WL-1:0];
   assign oVALID    = exitValid;

   // Tracks the population of valid bits: one enters at stage 0 while the
   // last stage's bit leaves, so only the mismatched cases move the count.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         oCOUNT <= '0;
      end else if (iCLR) begin
         oCOUNT <= '0;
      end else if (iEN) begin
         case ({iVALID, exitValid})
            2'b10:   oCOUNT <= oCOUNT + 1'b1;
            2'b01:   oCOUNT <= oCOUNT - 1'b1;
            default: oCOUNT <= oCOUNT;
         endcase
      end
   end

   assign oPRIMED = (oCOUNT == CW'(DEPTH));

endmodule

// File: tb/tb_data_delay_line.sv
// Bench for data_delay_line: a history-window model per instance checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_data_delay_line;

   localparam int WL0 = 10;
   localparam int D0  = 4;
   localparam int WL1 = 16;
   localparam int D1  = 1;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rstn;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT 0 : WL=10, DEPTH=4 ----------------
   logic           en, clr, vld;
   logic [WL0-1:0] dat;
   logic [WL0-1:0] out_data;
   logic           out_vld;
   logic [2:0]     out_cnt;
   logic           out_primed;

   data_delay_line #(.WL(WL0), .DEPTH(D0)) dut0 (
      .iCLK    (clk),
      .iRSTn   (rstn),
      .iEN     (en),
      .iCLR    (clr),
      .iVALID  (vld),
      .iDATA   (dat),
      .oDATA   (out_data),
      .oVALID  (out_vld),
      .oCOUNT  (out_cnt),
      .oPRIMED (out_primed)
   );

   // ---------------- DUT 1 : WL=16, DEPTH=1 ----------------
   logic           en1, clr1, vld1;
   logic [WL1-1:0] dat1;
   logic [WL1-1:0] out_data1;
   logic           out_vld1;
   logic [0:0]     out_cnt1;
   logic           out_primed1;

   data_delay_line #(.WL(WL1), .DEPTH(D1)) dut1 (
      .iCLK    (clk),
      .iRSTn   (rstn),
      .iEN     (en1),
      .iCLR    (clr1),
      .iVALID  (vld1),
      .iDATA   (dat1),
      .oDATA   (out_data1),
      .oVALID  (out_vld1),
      .oCOUNT  (out_cnt1),
      .oPRIMED (out_primed1)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // The model is a window over the last DEPTH samples accepted on enabled
   // edges: the oldest entry is what the output must show, the number of
   // valid entries is the count. Clear and reset refill the window with zeros.
   logic [WL0:0] exp_q[$];
   logic [WL1:0] exp1_q[$];

   task automatic model_flush0();
      exp_q.delete();
      for (int i = 0; i < D0; i++) exp_q.push_back('0);
   endtask

   task automatic model_flush1();
      exp1_q.delete();
      for (int i = 0; i < D1; i++) exp1_q.push_back('0);
   endtask

   initial begin
      model_flush0();
      model_flush1();
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         model_flush0();
         model_flush1();
      end else begin
         if (clr) model_flush0();
         else if (en) begin
            exp_q.push_back({vld, dat});
            void'(exp_q.pop_front());
         end
         if (clr1) model_flush1();
         else if (en1) begin
            exp1_q.push_back({vld1, dat1});
            void'(exp1_q.pop_front());
         end
      end
   end

   // Compare process: outputs are checked against the model on every falling edge.
   always @(negedge clk) begin
      logic [WL0:0] e0;
      logic [WL1:0] e1;
      int           c0;
      int           c1;
      e0 = exp_q[0];
      e1 = exp1_q[0];
      c0 = 0;
      c1 = 0;
      foreach (exp_q[i])  if (exp_q[i][WL0])  c0++;
      foreach (exp1_q[i]) if (exp1_q[i][WL1]) c1++;
      check("cmp0_data",   32'(out_data),    32'(e0[WL0-1:0]));
      check("cmp0_valid",  32'(out_vld),     32'(e0[WL0]));
      check("cmp0_count",  32'(out_cnt),     32'(c0));
      check("cmp0_primed", 32'(out_primed),  32'(c0 == D0));
      check("cmp1_data",   32'(out_data1),   32'(e1[WL1-1:0]));
      check("cmp1_valid",  32'(out_vld1),    32'(e1[WL1]));
      check("cmp1_count",  32'(out_cnt1),    32'(c1));
      check("cmp1_primed", 32'(out_primed1), 32'(c1 == D1));
   end

   // ---------------- driver ----------------
   task automatic drive(input logic e, input logic c, input logic v, input logic [WL0-1:0] d);
      en  = e;
      clr = c;
      vld = v;
      dat = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_out0(input string name, input logic [WL0-1:0] d, input logic v,
                             input logic [2:0] c, input logic p);
      check({name, "_data"},   32'(out_data),   32'(d));
      check({name, "_valid"},  32'(out_vld),    32'(v));
      check({name, "_count"},  32'(out_cnt),    32'(c));
      check({name, "_primed"}, 32'(out_primed), 32'(p));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      en = 0; clr = 0; vld = 0; dat = '0;
      en1 = 0; clr1 = 0; vld1 = 0; dat1 = '0;
      rstn = 1'b1;
      #1 rstn = 1'b0;
      @(negedge clk);
      check_out0("reset", 10'h000, 1'b0, 3'd0, 1'b0);
      check("reset1_data", 32'(out_data1), 32'h0);
      rstn = 1'b1;
      drive(0, 0, 0, 10'h000);

      // DEPTH=1, WL=16: one edge of latency
      en1 = 1; vld1 = 1; dat1 = 16'hBEEF;
      drive(0, 0, 0, 10'h000);
      check("d1_data",   32'(out_data1),   32'hBEEF);
      check("d1_valid",  32'(out_vld1),    32'h1);
      check("d1_count",  32'(out_cnt1),    32'h1);
      check("d1_primed", 32'(out_primed1), 32'h1);
      vld1 = 0; dat1 = 16'h1234;
      drive(0, 0, 0, 10'h000);
      check("d1_bubble_data",  32'(out_data1), 32'h1234);
      check("d1_bubble_count", 32'(out_cnt1),  32'h0);
      en1 = 0;

      // Latency: 1..4 in, count climbs, first sample out after the 4th edge
      drive(1, 0, 1, 10'd1); check_out0("lat1", 10'd0, 1'b0, 3'd1, 1'b0);
      drive(1, 0, 1, 10'd2); check_out0("lat2", 10'd0, 1'b0, 3'd2, 1'b0);
      drive(1, 0, 1, 10'd3); check_out0("lat3", 10'd0, 1'b0, 3'd3, 1'b0);
      drive(1, 0, 1, 10'd4); check_out0("lat4", 10'd1, 1'b1, 3'd4, 1'b1);

      // Stall: disabled edges hold everything
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 10'h3FF);
         check_out0("stall", 10'd1, 1'b1, 3'd4, 1'b1);
      end
      drive(1, 0, 1, 10'd5); check_out0("resume", 10'd2, 1'b1, 3'd4, 1'b1);

      // Clear beats enable; the sample on the clear edge is not captured
      drive(1, 1, 1, 10'h155); check_out0("clear", 10'd0, 1'b0, 3'd0, 1'b0);
      drive(1, 0, 0, 10'h000);
      drive(1, 0, 0, 10'h000);
      drive(1, 0, 0, 10'h000); check_out0("clear_nocap", 10'd0, 1'b0, 3'd0, 1'b0);

      // Bubbles: valid pattern 1,0,1,0
      drive(1, 0, 1, 10'h011);
      drive(1, 0, 0, 10'h022);
      drive(1, 0, 1, 10'h033);
      drive(1, 0, 0, 10'h044); check_out0("bub4", 10'h011, 1'b1, 3'd2, 1'b0);
      drive(1, 0, 0, 10'h000); check_out0("bub5", 10'h022, 1'b0, 3'd1, 1'b0);
      drive(1, 0, 0, 10'h000); check_out0("bub6", 10'h033, 1'b1, 3'd1, 1'b0);
      drive(1, 0, 0, 10'h000); check_out0("bub7", 10'h044, 1'b0, 3'd0, 1'b0);

      // Async reset mid-stream, then refill
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 10'(10'h100 + i));
      check_out0("preprime", 10'h100, 1'b1, 3'd4, 1'b1);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1 check_out0("async_rst", 10'h000, 1'b0, 3'd0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      drive(1, 0, 1, 10'h2A1);
      drive(1, 0, 1, 10'h2A2);
      drive(1, 0, 1, 10'h2A3); check_out0("refill3", 10'h000, 1'b0, 3'd3, 1'b0);
      drive(1, 0, 1, 10'h2A4); check_out0("refill4", 10'h2A1, 1'b1, 3'd4, 1'b1);

      // Mixed pattern of enable, clear and bubbles, checked by the model
      for (int i = 0; i < 24; i++) begin
         drive((i % 3) != 2, i == 13, (i % 4) != 1, 10'((i * 37 + 5) % 1024));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_delay_line.md
DATA_DELAY_LINE -- requirements
Module: data_delay_line

Interface
REQ-001 SHALL have parameter WL, default 10, meaning data word length in bits (WL >= 1).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of register stages (DEPTH >= 1).
REQ-003 SHALL have port iCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port iRSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iEN  input  1  advance enable; 1 shifts the line one stage, 0 holds every stage.
REQ-006 SHALL have port iCLR  input  1  synchronous clear of all stages.
REQ-007 SHALL have port iVALID  input  1  qualifier for iDATA.
REQ-008 SHALL have port iDATA  input  WL  sample entering stage 0.
REQ-009 SHALL have port oDATA  output  WL  content of stage DEPTH-1.
REQ-010 SHALL have port oVALID  output  1  valid bit of stage DEPTH-1.
REQ-011 SHALL have port oCOUNT  output  CW  number of valid stages, where CW = clog2(DEPTH+1).
REQ-012 SHALL have port oPRIMED  output  1  high when oCOUNT equals DEPTH.

Function
REQ-013 On an edge with iEN=1 and iCLR=0, the block SHALL load stage 0 from {iVALID, iDATA} and stage k from stage k-1 for k = 1..DEPTH-1.
REQ-014 On an edge with iEN=0 and iCLR=0, the block SHALL hold every stage's data and valid bits unchanged.
REQ-015 The block SHALL capture data into a stage regardless of the valid bit; valid travels alongside it.
REQ-016 Latency SHALL be exactly DEPTH enabled edges from iDATA to oDATA; disabled edges SHALL not count toward latency.
REQ-017 iCLR=1 SHALL zero all data bits, all valid bits and oCOUNT on that edge, with priority over iEN.
REQ-018 oCOUNT SHALL be registered and updated only on enabled edges.
REQ-019 On an enabled edge, oCOUNT SHALL increment by 1 when entering (iVALID) = 1 and exiting (oVALID) = 0.
REQ-020 On an enabled edge, oCOUNT SHALL decrement by 1 when entering = 0 and exiting = 1.
REQ-021 On an enabled edge, oCOUNT SHALL be unchanged when entering and exiting are equal.
REQ-022 oCOUNT SHALL always equal the population count of the stage valid bits; it SHALL never exceed DEPTH nor wrap below 0.
REQ-023 oPRIMED SHALL be combinational from oCOUNT and carry no extra latency.
REQ-024 With DEPTH=1, the block SHALL behave as a single enabled register carrying a valid bit; oCOUNT is 0 or 1.
REQ-025 Outputs SHALL be driven directly from registers, except oPRIMED (per REQ-023).

Reset
REQ-026 While iRSTn=0, the block SHALL asynchronously force all stage data to 0, all valid bits to 0 and oCOUNT to 0, giving oDATA=0, oVALID=0, oPRIMED=0.
REQ-027 After iRSTn deasserts, the first stage update SHALL occur on the next rising iCLK edge with iEN=1 or iCLR=1.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples, with no partial state retained.

Structure
REQ-029 The count-width function clog2 and the default WL and DEPTH constants SHALL live in the shared project package.
REQ-030 The block SHALL instantiate one sub-module, delay_stage: a WL+1-bit register with async active-low reset, synchronous clear and enable, generated DEPTH times.
REQ-031 oCOUNT logic SHALL reside in the top level.

Verification
REQ-032 Scenario, latency: WL=10, DEPTH=4, iEN=1 constantly, iVALID=1, iDATA=1,2,3,4,5 on consecutive edges -> oDATA=1 with oVALID=1 after the 4th edge, oCOUNT goes 1,2,3,4, oPRIMED=1 from the 4th edge.
REQ-033 Scenario, stall: prime with 1..4, then iEN=0 for 3 edges while iDATA=0x3FF -> oDATA stays 1, oCOUNT stays 4; at the next enabled edge oDATA=2.
REQ-034 Scenario, bubbles: enabled edges with iVALID pattern 1,0,1,0 -> oCOUNT=2 and oPRIMED=0; oVALID sequence at the output is 1,0,1,0 starting at edge 4.
REQ-035 Scenario, clear vs enable: primed line, then iCLR=1 and iEN=1 on one edge -> next cycle oDATA=0, oVALID=0, oCOUNT=0; iDATA on that edge is not captured.
REQ-036 Scenario, async reset: iRSTn pulsed low between clock edges while primed -> outputs go to 0 immediately without a clock edge, and a refill takes 4 enabled edges to reach oPRIMED=1.
REQ-037 Scenario, DEPTH=1 and WL=16: iEN=1, iDATA=0xBEEF, iVALID=1 -> oDATA=0xBEEF, oVALID=1 and oCOUNT=1 after 1 edge.
